// File: rtl/serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_tx: valid/ready word in, framed LSB-first serial line out.          |
// | Optional even-parity bit when PARITY_EN is defined.   Revision: 1.0        |
// +----------------------------------------------------------------------------+
module serial_tx #(
  parameter int DATA_W  = 8,
  parameter int BIT_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
`ifdef PARITY_EN
  logic              par_q, par_d;
`endif

  assign bit_end  = (cyc_q == CYC_LAST);
  assign tx_ready = ready_q;
  assign txd      = txd_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != S_IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + 1'b1;
    end

    // txd is registered, so each branch loads the level for the upcoming bit
    case (state_q)
      S_IDLE: begin
        if (tx_valid && ready_q) begin
          state_d = S_START;
          shift_d = tx_data;
`ifdef PARITY_EN
          par_d   = ^tx_data;
`endif
          cyc_d   = '0;
          txd_d   = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        txd_d   = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_tx: randomized self-checking bench for serial_tx.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_serial_tx;

  localparam int DATA_W  = 8;
  localparam int BIT_CYC = 4;
`ifdef PARITY_EN
  localparam int NBITS = DATA_W + 3;
`else
  localparam int NBITS = DATA_W + 2;
`endif
  localparam int F = NBITS * BIT_CYC;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready, txd, busy, done;

  int vectors = 0;
  int errors  = 0;

  serial_tx #(.DATA_W(DATA_W), .BIT_CYC(BIT_CYC)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Line level of frame bit j: start, data LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [DATA_W-1:0] w, input int j);
    if (j == 0) return 1'b0;
    if (j <= DATA_W) return w[j-1];
`ifdef PARITY_EN
    if (j == DATA_W + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // Expected {txd, tx_ready, busy, done} in cycle c after the accept edge (c >= 1).
  function automatic logic [3:0] exp_status(input logic [DATA_W-1:0] w, input int c);
    if (c <= F) return {frame_bit(w, (c - 1) / BIT_CYC), 1'b0, 1'b1, 1'b0};
    if (c == F + 1) return 4'b1101;
    return 4'b1100;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({txd, tx_ready, busy, done} !== 4'b1100) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got %b want 1100", i, {txd, tx_ready, busy, done});
      end
    end
  endtask

  // tx_data is scrambled every cycle after the accept edge to prove it is not re-sampled.
  task automatic test_frame(input logic [DATA_W-1:0] w);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int c = 1; c <= F + 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({txd, tx_ready, busy, done} !== exp_status(w, c)) begin
        errors++;
        $display("FAIL frame w=%h cyc=%0d got %b want %b", w, c,
                 {txd, tx_ready, busy, done}, exp_status(w, c));
      end
      tx_data = DATA_W'($urandom);
    end
  endtask

  task automatic test_back_to_back(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1);
    int done_t0, done_t1, t;
    done_t0 = -1;
    done_t1 = -1;
    t = 0;
    @(negedge clk);
    tx_data  = w0;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = w1;
    for (int c = 1; c <= F + 1; c++) begin
      @(negedge clk);
      t++;
      if (done === 1'b1) done_t0 = t;
      vectors++;
      if ({txd, tx_ready, busy, done} !== exp_status(w0, c)) begin
        errors++;
        $display("FAIL b2b_first cyc=%0d got %b want %b", c,
                 {txd, tx_ready, busy, done}, exp_status(w0, c));
      end
    end
    // tx_valid is still high in the done cycle, so the next edge accepts w1
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int c = 1; c <= F + 2; c++) begin
      @(negedge clk);
      t++;
      if (done === 1'b1) done_t1 = t;
      vectors++;
      if ({txd, tx_ready, busy, done} !== exp_status(w1, c)) begin
        errors++;
        $display("FAIL b2b_second cyc=%0d got %b want %b", c,
                 {txd, tx_ready, busy, done}, exp_status(w1, c));
      end
    end
    // One done cycle separates the frames: second done lands F+1 cycles after the first
    vectors++;
    if (done_t1 - done_t0 !== F + 1) begin
      errors++;
      $display("FAIL b2b_done_spacing got %0d want %0d", done_t1 - done_t0, F + 1);
    end
  endtask

  task automatic test_ignore_busy(input logic [DATA_W-1:0] w);
    int dones;
    dones = 0;
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int c = 1; c <= F + 2; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      vectors++;
      if ({txd, tx_ready, busy, done} !== exp_status(w, c)) begin
        errors++;
        $display("FAIL ignore_busy cyc=%0d got %b want %b", c,
                 {txd, tx_ready, busy, done}, exp_status(w, c));
      end
      if (c == 3 * BIT_CYC) begin
        tx_data  = '1;
        tx_valid = 1'b1;
      end else if (c == 3 * BIT_CYC + 1) begin
        tx_valid = 1'b0;
      end
    end
    vectors++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_busy_dones got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid(input logic [DATA_W-1:0] w);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    // Data bit 3 is frame bit 4: cycles 4*BIT_CYC+1 .. 5*BIT_CYC
    repeat (4 * BIT_CYC + 2) @(negedge clk);
    vectors++;
    if ({txd, busy} !== {w[3], 1'b1}) begin
      errors++;
      $display("FAIL mid_bit3 got %b want %b", {txd, busy}, {w[3], 1'b1});
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({txd, tx_ready, busy, done} !== 4'b1100) begin
      errors++;
      $display("FAIL mid_reset got %b want 1100", {txd, tx_ready, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      vectors++;
      if ({txd, tx_ready, busy, done} !== 4'b1100) begin
        errors++;
        $display("FAIL mid_after cyc=%0d got %b want 1100", i, {txd, tx_ready, busy, done});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame(8'hA5);
    for (int i = 0; i < 4; i++) test_frame(DATA_W'($urandom));
    test_frame(8'h00);
    test_frame(8'hFF);
    test_back_to_back(8'h3C, 8'hC3);
    test_ignore_busy(8'h5A);
    test_reset_mid(8'h08 | DATA_W'($urandom));
    test_frame(8'h01);
`ifdef PARITY_EN
    test_frame(8'hA5);
    test_frame(8'h07);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
